chacha20_char_serializer: RTL and testbench

- Upstream feeder for the 8-bit character input PIO of the ChaCha20 embedded system.
- Accepts 32-bit keystream/ciphertext words from the ChaCha20 core via valid/ready and splits each word into bytes, least-significant byte first (ChaCha20 little-endian order).
- Buffers the bytes in a small FIFO and presents the head byte on char_out, which drives the PIO in_port.
- The CPU acknowledges each consumed character by toggling a bit through a separate output PIO.

---
 rtl/chacha20_char_serializer_if.sv | 25 ++
 rtl/chacha20_char_serializer.sv | 102 ++++++++++
 tb/tb_chacha20_char_serializer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/chacha20_char_serializer_if.sv
// Handshake and character bus between the ChaCha20 core, the serializer and the CPU PIOs.
// The slave modport is the serializer's view; the master modport is its environment.
interface chacha20_char_serializer_if #(
  parameter int FIFO_DEPTH = 16,
  parameter int CW         = $clog2(FIFO_DEPTH) + 1
);
  logic [31:0]   word_in;
  logic          word_valid;
  logic          word_ready;
  logic [7:0]    char_out;
  logic          char_valid;
  logic          ack_toggle;
  logic [CW-1:0] fifo_count;
  logic          underflow;

  modport slave (
    input  word_in, word_valid, ack_toggle,
    output word_ready, char_out, char_valid, fifo_count, underflow
  );

  modport master (
    output word_in, word_valid, ack_toggle,
    input  word_ready, char_out, char_valid, fifo_count, underflow
  );
endinterface

// File: rtl/chacha20_char_serializer.sv
// Splits 32-bit ChaCha20 words into bytes (LSB first) and feeds them through a byte FIFO
// to the CPU character PIO; the CPU pops one byte per level change of ack_toggle.
module chacha20_char_serializer #(
  parameter int FIFO_DEPTH = 16,
  parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            reset,
  chacha20_char_serializer_if.slave       bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   shift_q, shift_d;
  logic [1:0]    idx_q, idx_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          underflow_q, underflow_d;
  logic          ack_q;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic          full, empty, ack_evt, push, pop, word_ready;

  // Full/empty come from the registered count, so a pop while full cannot unblock a push
  // until the following cycle.
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign ack_evt = (bus.ack_toggle != ack_q);
  assign pop     = ack_evt && !empty;
  assign push    = (state_q == SHIFT) && !full;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    word_ready  = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    underflow_d = underflow_q;

    unique case (state_q)
      IDLE: begin
        word_ready = 1'b1;
        if (bus.word_valid) begin
          shift_d = bus.word_in;
          idx_d   = 2'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (push) begin
          shift_d = {8'h00, shift_q[31:8]};
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
    if (ack_evt && empty) underflow_d = 1'b1;
  end

  // Control state: reset loads ack_q from the live input so a held-high toggle is not an event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
      ack_q       <= bus.ack_toggle;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
      ack_q       <= bus.ack_toggle;
    end
  end

  // Datapath storage: contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (push && !reset) mem_q[wr_ptr_q] <= shift_q[7:0];
  end

  assign bus.word_ready = word_ready;
  assign bus.char_out   = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign bus.char_valid = !empty;
  assign bus.fifo_count = count_q;
  assign bus.underflow  = underflow_q;
endmodule

// File: tb/tb_chacha20_char_serializer.sv
// Directed bench for the ChaCha20 character serializer: per-cycle vector table plus
// hand-written sequences for FIFO-full stall and reset during serialization.
module tb_chacha20_char_serializer;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  chacha20_char_serializer_if #(.FIFO_DEPTH(DEPTH)) bus ();

  chacha20_char_serializer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        wv;
    logic [31:0] w;
    logic        ack;
    logic        rdy;
    logic [7:0]  ch;
    logic        cv;
    int          cnt;
    logic        uf;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic wv, input logic [31:0] w, input logic ack,
                              input logic rdy, input logic [7:0] ch, input logic cv,
                              input int cnt, input logic uf);
    vec_t v;
    v.wv = wv; v.w = w; v.ack = ack; v.rdy = rdy; v.ch = ch; v.cv = cv; v.cnt = cnt; v.uf = uf;
    tbl.push_back(v);
  endfunction

  task automatic chk_outs(input string tag, input logic rdy, input logic [7:0] ch,
                          input logic cv, input int cnt, input logic uf);
    chk({tag, ".word_ready"}, {31'd0, bus.word_ready}, {31'd0, rdy});
    chk({tag, ".char_out"},   {24'd0, bus.char_out},   {24'd0, ch});
    chk({tag, ".char_valid"}, {31'd0, bus.char_valid}, {31'd0, cv});
    chk({tag, ".fifo_count"}, 32'(bus.fifo_count),     32'(cnt));
    chk({tag, ".underflow"},  {31'd0, bus.underflow},  {31'd0, uf});
  endtask

  // Called at a negedge; presents the word for exactly one accepting edge.
  task automatic send_word(input logic [31:0] w);
    int n = 0;
    while (!bus.word_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.word_ready) begin
      checks++;
      errors++;
      $display("FAIL send_word_timeout: word_ready=%0b required 1", bus.word_ready);
    end
    bus.word_in    = w;
    bus.word_valid = 1'b1;
    @(negedge clk);
    bus.word_valid = 1'b0;
  endtask

  task automatic do_reset(input logic ack_level);
    @(negedge clk);
    bus.ack_toggle = ack_level;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    bus.word_in    = 32'h0;
    bus.word_valid = 1'b0;
    bus.ack_toggle = 1'b0;

    // Serialize, acknowledge, simultaneous push/pop, word_in change during SHIFT, underflow.
    add(1, 32'h44332211, 0,  0, 8'h00, 0, 0, 0);
    add(0, 32'h0,        0,  0, 8'h11, 1, 1, 0);
    add(0, 32'h0,        0,  0, 8'h11, 1, 2, 0);
    add(0, 32'h0,        0,  0, 8'h11, 1, 3, 0);
    add(0, 32'h0,        0,  1, 8'h11, 1, 4, 0);
    add(0, 32'h0,        1,  1, 8'h22, 1, 3, 0);
    add(0, 32'h0,        1,  1, 8'h22, 1, 3, 0);
    add(0, 32'h0,        1,  1, 8'h22, 1, 3, 0);
    add(0, 32'h0,        0,  1, 8'h33, 1, 2, 0);
    add(0, 32'h0,        0,  1, 8'h33, 1, 2, 0);
    add(0, 32'h0,        0,  1, 8'h33, 1, 2, 0);
    add(0, 32'h0,        1,  1, 8'h44, 1, 1, 0);
    add(0, 32'h0,        1,  1, 8'h44, 1, 1, 0);
    add(0, 32'h0,        1,  1, 8'h44, 1, 1, 0);
    add(0, 32'h0,        0,  1, 8'h00, 0, 0, 0);
    add(1, 32'hDDCCBBAA, 0,  0, 8'h00, 0, 0, 0);
    add(0, 32'hFFFFFFFF, 0,  0, 8'hAA, 1, 1, 0);
    add(0, 32'hFFFFFFFF, 0,  0, 8'hAA, 1, 2, 0);
    add(0, 32'hFFFFFFFF, 1,  0, 8'hBB, 1, 2, 0);
    add(0, 32'h0,        1,  1, 8'hBB, 1, 3, 0);
    add(0, 32'h0,        0,  1, 8'hCC, 1, 2, 0);
    add(0, 32'h0,        1,  1, 8'hDD, 1, 1, 0);
    add(0, 32'h0,        0,  1, 8'h00, 0, 0, 0);
    add(0, 32'h0,        1,  1, 8'h00, 0, 0, 1);
    add(0, 32'h0,        1,  1, 8'h00, 0, 0, 1);
    add(0, 32'h0,        0,  1, 8'h00, 0, 0, 1);

    repeat (2) @(negedge clk);
    chk_outs("reset", 1'b1, 8'h00, 1'b0, 0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      bus.word_valid = tbl[i].wv;
      bus.word_in    = tbl[i].w;
      bus.ack_toggle = tbl[i].ack;
      @(posedge clk);
      #1;
      chk_outs($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].ch, tbl[i].cv, tbl[i].cnt, tbl[i].uf);
      @(negedge clk);
    end
    bus.word_valid = 1'b0;

    // FIFO full: five words, fifth stalls on its first byte until a pop frees a slot.
    do_reset(1'b0);
    @(negedge clk);
    chk("uf_cleared_by_reset", {31'd0, bus.underflow}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      logic [7:0] b0;
      b0 = 8'(4 * k);
      send_word({b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0});
    end
    repeat (6) @(negedge clk);
    chk_outs("full_stall", 1'b0, 8'h00, 1'b1, DEPTH, 1'b0);
    bus.ack_toggle = ~bus.ack_toggle;
    @(negedge clk);
    chk("pop_while_full.count", 32'(bus.fifo_count), 32'(DEPTH - 1));
    chk("pop_while_full.head",  {24'd0, bus.char_out}, 32'h01);
    @(negedge clk);
    chk("push_after_pop.count", 32'(bus.fifo_count), 32'(DEPTH));
    for (int i = 1; i < 20; i++) begin
      chk($sformatf("drain%0d", i), {24'd0, bus.char_out}, 32'(i));
      bus.ack_toggle = ~bus.ack_toggle;
      repeat (2) @(negedge clk);
    end
    chk_outs("drained", 1'b1, 8'h00, 1'b0, 0, 1'b0);

    // ack_toggle held high through reset; reset again mid-SHIFT at byte index 2.
    do_reset(1'b1);
    repeat (3) @(negedge clk);
    chk_outs("ack_high_release", 1'b1, 8'h00, 1'b0, 0, 1'b0);
    send_word(32'hA3A2A1A0);
    bus.word_in = 32'h5A5A5A5A;
    repeat (2) @(negedge clk);
    chk("mid_shift.count", 32'(bus.fifo_count), 32'd2);
    chk("mid_shift.head",  {24'd0, bus.char_out}, 32'hA0);
    reset = 1'b1;
    @(negedge clk);
    chk_outs("reset_mid_shift", 1'b1, 8'h00, 1'b0, 0, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk_outs("after_mid_reset", 1'b1, 8'h00, 1'b0, 0, 1'b0);
    send_word(32'hB3B2B1B0);
    repeat (4) @(negedge clk);
    chk_outs("next_word", 1'b1, 8'hB0, 1'b1, 4, 1'b0);
    bus.ack_toggle = 1'b0;
    @(negedge clk);
    chk_outs("next_word_pop", 1'b1, 8'hB1, 1'b1, 3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
